rgb_pwm_sequencer: RTL and testbench

Parametrised multi-channel RGB PWM colour sequencer for the celebration and status LEDs. It cross-fades each tri-colour LED through a 6-colour wheel using PWM blending between the current and next colour. It supports several modes (off, rainbow fade, blink, solid), per-channel phase offset, enable/hold and a restart. It sits between the game controller (mode/enable/restart) and the board RGB LED pins.

---
 rtl/rgb_pwm_sequencer_pkg.sv | 26 ++
 rtl/rgb_pwm_sequencer_lut.sv | 22 ++
 rtl/rgb_pwm_sequencer.sv | 106 ++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared encodings for the RGB PWM colour sequencer: modes, wheel colours
// and the colour-wheel step successor.
package rgb_pwm_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_RAINBOW = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_t;

    // Colours are packed {blu, grn, red}
    localparam logic [2:0] C_RED     = 3'b001;
    localparam logic [2:0] C_YELLOW  = 3'b011;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_CYAN    = 3'b110;
    localparam logic [2:0] C_BLUE    = 3'b100;
    localparam logic [2:0] C_MAGENTA = 3'b101;

    localparam logic [2:0] STEP_LAST = 3'd5;

    function automatic logic [2:0] next_step(input logic [2:0] s);
        return (s == STEP_LAST) ? 3'd0 : s + 3'd1;
    endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_lut.sv
// Colour-wheel lookup: step 0..5 -> {blu, grn, red}.
module rgb_color_lut
    import rgb_pwm_sequencer_pkg::*;
(
    input  logic [2:0] step,
    output logic [2:0] color
);

    always_comb begin
        color = C_RED;
        case (step)
            3'd0:    color = C_RED;
            3'd1:    color = C_YELLOW;
            3'd2:    color = C_GREEN;
            3'd3:    color = C_CYAN;
            3'd4:    color = C_BLUE;
            3'd5:    color = C_MAGENTA;
            default: color = C_RED;
        endcase
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel RGB PWM sequencer: cross-fades each LED around a 6-colour
// wheel, with blink, solid and off modes and a per-channel phase offset.
module rgb_pwm_sequencer
    import rgb_pwm_sequencer_pkg::*;
#(
    parameter int PWM_BITS   = 12,
    parameter int NUM_LEDS   = 2,
    parameter int PHASE_STEP = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                restart,
    input  logic [2:0]          solid_color,
    output logic [NUM_LEDS-1:0] red,
    output logic [NUM_LEDS-1:0] grn,
    output logic [NUM_LEDS-1:0] blu,
    output logic [2:0]          step_out,
    output logic                wheel_done
);

    logic [PWM_BITS-1:0] t;
    logic [PWM_BITS-1:0] duty;
    logic [2:0]          step;
    logic                t_max;
    logic                duty_max;
    mode_t               mode_e;

    assign t_max    = (t == '1);
    assign duty_max = (duty == '1);
    assign mode_e   = mode_t'(mode);
    assign step_out = step;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            t          <= '0;
            duty       <= '0;
            step       <= '0;
            wheel_done <= 1'b0;
        end else begin
            wheel_done <= 1'b0;
            if (enable) begin
                t <= t + 1'b1;
                if (t_max) begin
                    duty <= duty + 1'b1;
                    if (duty_max) begin
                        step       <= next_step(step);
                        wheel_done <= (step == STEP_LAST);
                    end
                end
            end
        end
    end

    logic [NUM_LEDS-1:0] red_d;
    logic [NUM_LEDS-1:0] grn_d;
    logic [NUM_LEDS-1:0] blu_d;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        // Phase offset folded to 0..5 at elaboration, so the add stays within 4 bits
        localparam logic [3:0] OFFS = 4'((i * PHASE_STEP) % 6);

        logic [3:0] sum;
        logic [2:0] cs;
        logic [2:0] cs_nxt;
        logic [2:0] cur_c;
        logic [2:0] nxt_c;
        logic [2:0] pix;

        assign sum    = {1'b0, step} + OFFS;
        assign cs     = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
        assign cs_nxt = next_step(cs);

        rgb_color_lut u_cur (.step(cs),     .color(cur_c));
        rgb_color_lut u_nxt (.step(cs_nxt), .color(nxt_c));

        always_comb begin
            pix = 3'b000;
            case (mode_e)
                MODE_OFF:     pix = 3'b000;
                MODE_RAINBOW: pix = (t < duty) ? nxt_c : cur_c;
                MODE_BLINK:   pix = duty[PWM_BITS-1] ? 3'b000 : cur_c;
                MODE_SOLID:   pix = solid_color;
                default:      pix = 3'b000;
            endcase
        end

        assign red_d[i] = pix[0];
        assign grn_d[i] = pix[1];
        assign blu_d[i] = pix[2];
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            red <= '0;
            grn <= '0;
            blu <= '0;
        end else begin
            red <= red_d;
            grn <= grn_d;
            blu <= blu_d;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer: directed walk-through plus random phases,
// checked against a position-on-the-wheel reference model.
module tb_rgb_pwm_sequencer;

    localparam int PB    = 2;
    localparam int NL    = 2;
    localparam int PS    = 2;
    localparam int TP    = 1 << PB;
    localparam int WHEEL = 6 * TP * TP;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    mode;
    logic          restart;
    logic [2:0]    solid_color;
    logic [NL-1:0] red;
    logic [NL-1:0] grn;
    logic [NL-1:0] blu;
    logic [2:0]    step_out;
    logic          wheel_done;

    int cmp = 0;
    int mis = 0;
    int pos = 0;          // enabled cycles since last zeroing, mod WHEEL
    int wd_count;
    int wd_at;

    logic [2:0] wheel [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    rgb_pwm_sequencer #(.PWM_BITS(PB), .NUM_LEDS(NL), .PHASE_STEP(PS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .restart(restart), .solid_color(solid_color),
        .red(red), .grn(grn), .blu(blu),
        .step_out(step_out), .wheel_done(wheel_done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_color(input int ch, input int p);
        int tt, dd, cs;
        tt = p % TP;
        dd = (p / TP) % TP;
        cs = ((p / (TP * TP)) + ch * PS) % 6;
        if (!enable) return 3'b000;
        case (mode)
            2'd1:    return (tt < dd) ? wheel[(cs + 1) % 6] : wheel[cs];
            2'd2:    return (dd >= TP / 2) ? 3'b000 : wheel[cs];
            2'd3:    return solid_color;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] ch_of(input int ch);
        return {blu[ch], grn[ch], red[ch]};
    endfunction

    task automatic tick();
        logic [NL-1:0] er, eg, eb;
        logic [2:0]    c;
        logic [2:0]    es;
        logic          ewd;
        int            npos;
        for (int i = 0; i < NL; i++) begin
            c = reset ? 3'b000 : model_color(i, pos);
            er[i] = c[0];
            eg[i] = c[1];
            eb[i] = c[2];
        end
        if (reset || restart) begin
            npos = 0;
            ewd  = 1'b0;
        end else if (enable) begin
            npos = (pos + 1) % WHEEL;
            ewd  = (pos == WHEEL - 1);
        end else begin
            npos = pos;
            ewd  = 1'b0;
        end
        @(posedge clk);
        #1;
        pos = npos;
        es  = 3'(npos / (TP * TP));
        cmp++;
        assert ({blu, grn, red} === {eb, eg, er}) else begin
            mis++;
            $error("FAIL rgb observed=%b expected=%b pos=%0d", {blu, grn, red}, {eb, eg, er}, pos);
        end
        cmp++;
        assert (step_out === es) else begin
            mis++;
            $error("FAIL step_out observed=%0d expected=%0d", step_out, es);
        end
        cmp++;
        assert (wheel_done === ewd) else begin
            mis++;
            $error("FAIL wheel_done observed=%b expected=%b", wheel_done, ewd);
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        mode        = 2'd1;
        restart     = 1'b0;
        solid_color = 3'b000;
        repeat (3) tick();

        // full wheel from reset, rainbow
        reset    = 1'b0;
        wd_count = 0;
        wd_at    = 0;
        for (int k = 1; k <= WHEEL; k++) begin
            tick();
            if (wheel_done) begin
                wd_count++;
                wd_at = k;
            end
            if (k == 1) begin
                cmp++;
                assert (ch_of(0) === 3'b001) else begin
                    mis++;
                    $error("FAIL first_pix observed=%b expected=001", ch_of(0));
                end
            end
            if (k == 81) begin
                cmp++;
                assert ({ch_of(1), ch_of(0)} === {3'b011, 3'b101}) else begin
                    mis++;
                    $error("FAIL phase observed=%b expected=011101", {ch_of(1), ch_of(0)});
                end
            end
        end
        cmp++;
        assert (wd_count == 1 && wd_at == WHEEL) else begin
            mis++;
            $error("FAIL wheel_pulse observed=%0d@%0d expected=1@%0d", wd_count, wd_at, WHEEL);
        end

        // hold at step 2 with enable low
        for (int n = 0; n < 200 && pos != 2 * TP * TP + 5; n++) tick();
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        repeat (6) tick();

        // restart at step 4, then reset + restart together
        for (int n = 0; n < 200 && pos / (TP * TP) != 4; n++) tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (3) tick();
        reset   = 1'b1;
        restart = 1'b1;
        tick();
        reset   = 1'b0;
        restart = 1'b0;
        repeat (2) tick();

        // solid then blink entered with duty MSB set
        mode        = 2'd3;
        solid_color = 3'b110;
        tick();
        cmp++;
        assert ({ch_of(1), ch_of(0)} === {3'b110, 3'b110}) else begin
            mis++;
            $error("FAIL solid observed=%b expected=110110", {ch_of(1), ch_of(0)});
        end
        for (int n = 0; n < 200 && (pos % (TP * TP)) != TP * TP / 2; n++) tick();
        mode = 2'd2;
        repeat (12) tick();

        // restart while disabled
        enable  = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        mode   = 2'd1;
        repeat (4) tick();

        // random phase
        for (int n = 0; n < 600; n++) begin
            enable      = ($urandom_range(0, 9) != 0);
            restart     = ($urandom_range(0, 59) == 0);
            reset       = ($urandom_range(0, 149) == 0);
            solid_color = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end
        reset   = 1'b0;
        restart = 1'b0;
        enable  = 1'b1;
        mode    = 2'd1;
        repeat (WHEEL + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
